// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: one pipeline register stage with a valid/ready handshake
// and a one-entry skid buffer, so both IN_READY and OUT_VALID/OUT_DATA come
// straight from flops and the stage still sustains one payload per cycle.
//
// Optional feature macro: PIPE_PERF_CNT_EN
//   When defined, the STALL_CNT and BUBBLE_CNT ports and their saturating
//   counters are present. When undefined, both ports and all counter logic
//   are absent and the datapath behaves identically.
//
// Handshake: a transfer happens on a rising CLK edge where valid and ready
// are both 1 on the same side (push = IN_VALID & IN_READY upstream,
// pop = OUT_VALID & OUT_READY downstream). IN_VALID/IN_DATA are ignored
// while IN_READY is 0. FLUSH overrides both handshakes for that cycle: the
// offered input is dropped, while a pop in that cycle still counts downstream.
//
// The FSM state is the pair {skid_v, main_v}; the encoding is chosen so the
// valid bits are plain bits of the state register (state_q is the debug view
// of the FSM for checkers bound into this module).

module pipe_skid_stage #(
  parameter int DATA_W = 66,
  parameter int CNT_W  = 32
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              FLUSH,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [DATA_W-1:0] IN_DATA,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [DATA_W-1:0] OUT_DATA
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  STALL_CNT,
  output logic [CNT_W-1:0]  BUBBLE_CNT
`endif
);

  // {skid_v, main_v}; 2'b10 is never entered
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    FULL  = 2'b01,
    SKID  = 2'b11
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [DATA_W-1:0]   main_q;
  logic [DATA_W-1:0]   main_d;
  logic [DATA_W-1:0]   skid_q;
  logic [DATA_W-1:0]   skid_d;
  logic                in_ready_q;

  logic                main_v;
  logic                skid_v;
  logic                push;
  logic                pop;

  assign main_v = state_q[0];
  assign skid_v = state_q[1];

  // Handshake events as seen at the coming clock edge
  assign push = IN_VALID & in_ready_q;
  assign pop  = main_v & OUT_READY;

  // Outputs are taken directly from registers, no combinational path
  assign IN_READY  = in_ready_q;
  assign OUT_VALID = main_v;
  assign OUT_DATA  = main_q;

  // Next-state and next-data: flush wins, otherwise follow the handshake events
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (FLUSH) begin
      state_d = EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            state_d = FULL;
            main_d  = IN_DATA;
          end
        end
        FULL: begin
          case ({push, pop})
            2'b11: begin
              // Streaming: replace the departing word in place
              main_d = IN_DATA;
            end
            2'b10: begin
              // Downstream stalled: the word accepted this cycle parks in skid
              state_d = SKID;
              skid_d  = IN_DATA;
            end
            2'b01: begin
              // main_q keeps the popped word; OUT_VALID=0 marks it stale
              state_d = EMPTY;
            end
            default: begin
              state_d = FULL;
            end
          endcase
        end
        SKID: begin
          // IN_READY is 0 here, so only the older skid word can move up
          if (pop) begin
            state_d = FULL;
            main_d  = skid_q;
          end
        end
        default: begin
          // Unreachable encoding; recover to a clean empty stage
          state_d = EMPTY;
        end
      endcase
    end
  end

  // State register and ready flop; ready tracks "skid slot free next cycle"
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= ~state_d[1];
    end
  end

  // Payload registers; cleared on reset so no X ever reaches OUT_DATA
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] bubble_q;

  assign STALL_CNT  = stall_q;
  assign BUBBLE_CNT = bubble_q;

  // Saturating stall/bubble counters; flush cycles are not counted, and
  // only reset clears them so redirects do not lose the statistics
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else if (!FLUSH) begin
      if (main_v && !OUT_READY && (stall_q != CNT_MAX)) begin
        stall_q <= stall_q + CNT_ONE;
      end
      if (!main_v && (bubble_q != CNT_MAX)) begin
        bubble_q <= bubble_q + CNT_ONE;
      end
    end
  end
`endif

endmodule
